// File: rtl/alu_result_checker.sv
// -----------------------------------------------------------------------------
// alu_result_checker
//
// Response-side checker for the 32-bit ALU unit benches. Expected results are
// queued through a valid/ready channel into a small FIFO. Each DUT result
// strobe pops the oldest expected word and compares it against the result.
// The outcome is reported one cycle later as a match/mismatch pulse, together
// with saturating pass/error counters.
//
// Parameters
//   WIDTH  data width of expected/result words
//   DEPTH  expected-FIFO depth (power of 2, >= 2)
//   CNT_W  width of the pass/error counters
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous flush of FIFO, counters, flags, pending compare
//   exp_valid  in   expected word offered
//   exp_ready  out  FIFO can accept (= !full)
//   exp_data   in   expected word
//   res_valid  in   DUT result strobe (no backpressure)
//   res_data   in   DUT result word
//   mismatch   out  1-cycle pulse, compare failed
//   match      out  1-cycle pulse, compare passed
//   unexpected out  sticky, a result arrived while the FIFO was empty
//   pass_count out  saturating count of matches
//   err_count  out  saturating count of mismatches
//   fifo_level out  FIFO occupancy
//
// Optional feature (macro CHK_ERR_LOG_EN)
//   Adds first_err_valid / first_err_idx / first_err_exp / first_err_got,
//   which capture the first mismatch since reset or clear. The index counts
//   every compare, starting at 0.
// -----------------------------------------------------------------------------
module alu_result_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  logic [WIDTH-1:0]       exp_data,
  input  logic                   res_valid,
  input  logic [WIDTH-1:0]       res_data,
  output logic                   mismatch,
  output logic                   match,
  output logic                   unexpected,
  output logic [CNT_W-1:0]       pass_count,
  output logic [CNT_W-1:0]       err_count,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef CHK_ERR_LOG_EN
  ,
  output logic                   first_err_valid,
  output logic [CNT_W-1:0]       first_err_idx,
  output logic [WIDTH-1:0]       first_err_exp,
  output logic [WIDTH-1:0]       first_err_got
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CMP  = 2'd2
  } state_t;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_nxt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic             w_eq;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_eq_p0;

  logic             r_unexp;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // clear overrides both directions. A result against an empty FIFO never
  // bypasses a word being pushed in the same cycle.
  assign w_push  = exp_valid & ~w_full & ~clear;
  assign w_pop   = res_valid & ~w_empty & ~clear;

  // Written as an if/else so an unknown result word lands in the mismatch
  // branch in simulation rather than propagating X into the pulses.
  always_comb begin
    w_eq = 1'b0;
    if (res_data == w_head) begin
      w_eq = 1'b1;
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  // ---- stage p0: FIFO storage and pointers ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= exp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
    end
  end

  // ---- stage p0 -> p1: compare result register and sequencing ----
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_eq_p0 <= w_eq;
    end
  end

  // CMP marks that r_eq_p0 holds a fresh result; the pulses are only
  // visible while in CMP, so a dropped compare (clear/reset) never pulses.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else if (w_pop) begin
      w_state_nxt = ST_CMP;
    end else if (w_level_nxt != '0) begin
      w_state_nxt = ST_LOAD;
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters move on the same edge that loads the compare register, so they
  // change in the cycle the pulse is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unexp    <= 1'b0;
      r_pass_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (clear) begin
      r_unexp    <= 1'b0;
      r_pass_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (res_valid && w_empty) begin
        r_unexp <= 1'b1;
      end
      if (w_pop) begin
        if (w_eq) r_pass_cnt <= sat_inc(r_pass_cnt);
        else      r_err_cnt  <= sat_inc(r_err_cnt);
      end
    end
  end

`ifdef CHK_ERR_LOG_EN
  logic             r_fe_valid;
  logic [CNT_W-1:0] r_fe_idx;
  logic [WIDTH-1:0] r_fe_exp;
  logic [WIDTH-1:0] r_fe_got;
  logic [CNT_W-1:0] r_cmp_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fe_valid <= 1'b0;
      r_fe_idx   <= '0;
      r_fe_exp   <= '0;
      r_fe_got   <= '0;
      r_cmp_idx  <= '0;
    end else if (clear) begin
      r_fe_valid <= 1'b0;
      r_fe_idx   <= '0;
      r_fe_exp   <= '0;
      r_fe_got   <= '0;
      r_cmp_idx  <= '0;
    end else if (w_pop) begin
      r_cmp_idx <= sat_inc(r_cmp_idx);
      if (!w_eq && !r_fe_valid) begin
        r_fe_valid <= 1'b1;
        r_fe_idx   <= r_cmp_idx;
        r_fe_exp   <= w_head;
        r_fe_got   <= res_data;
      end
    end
  end

  assign first_err_valid = r_fe_valid;
  assign first_err_idx   = r_fe_idx;
  assign first_err_exp   = r_fe_exp;
  assign first_err_got   = r_fe_got;
`endif

  // ---- stage p1: outputs ----
  assign exp_ready  = ~w_full;
  assign match      = (r_state == ST_CMP) &  r_eq_p0;
  assign mismatch   = (r_state == ST_CMP) & ~r_eq_p0;
  assign unexpected = r_unexp;
  assign pass_count = r_pass_cnt;
  assign err_count  = r_err_cnt;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clear;
  logic                   exp_valid;
  logic                   exp_ready;
  logic [WIDTH-1:0]       exp_data;
  logic                   res_valid;
  logic [WIDTH-1:0]       res_data;
  logic                   mismatch;
  logic                   match;
  logic                   unexpected;
  logic [CNT_W-1:0]       pass_count;
  logic [CNT_W-1:0]       err_count;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef CHK_ERR_LOG_EN
  logic                   first_err_valid;
  logic [CNT_W-1:0]       first_err_idx;
  logic [WIDTH-1:0]       first_err_exp;
  logic [WIDTH-1:0]       first_err_got;
`endif

  alu_result_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .exp_valid  (exp_valid),
    .exp_ready  (exp_ready),
    .exp_data   (exp_data),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .mismatch   (mismatch),
    .match      (match),
    .unexpected (unexpected),
    .pass_count (pass_count),
    .err_count  (err_count),
    .fifo_level (fifo_level)
`ifdef CHK_ERR_LOG_EN
    ,
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .first_err_exp   (first_err_exp),
    .first_err_got   (first_err_got)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of outstanding expectations plus scoreboard state.
  logic [WIDTH-1:0] mq[$];
  int   m_pass, m_err, m_cidx;
  bit   m_unexp, m_match, m_mism;
  bit   m_fe_v;
  int   m_fe_idx;
  logic [WIDTH-1:0] m_fe_exp, m_fe_got;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pass = 0; m_err = 0; m_cidx = 0;
    m_unexp = 0; m_match = 0; m_mism = 0;
    m_fe_v = 0; m_fe_idx = 0; m_fe_exp = '0; m_fe_got = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".match"},    32'(match),      32'(m_match));
    chk({tag, ".mismatch"}, 32'(mismatch),   32'(m_mism));
    chk({tag, ".unexp"},    32'(unexpected), 32'(m_unexp));
    chk({tag, ".pass"},     32'(pass_count), 32'(m_pass));
    chk({tag, ".err"},      32'(err_count),  32'(m_err));
    chk({tag, ".level"},    32'(fifo_level), 32'(mq.size()));
    chk({tag, ".ready"},    32'(exp_ready),  32'(mq.size() < DEPTH));
`ifdef CHK_ERR_LOG_EN
    chk({tag, ".fe_valid"}, 32'(first_err_valid), 32'(m_fe_v));
    if (m_fe_v) begin
      chk({tag, ".fe_idx"}, 32'(first_err_idx), 32'(m_fe_idx));
      chk({tag, ".fe_exp"}, first_err_exp, m_fe_exp);
      chk({tag, ".fe_got"}, first_err_got, m_fe_got);
    end
`endif
  endtask

  // One clock: drive at negedge, advance the model at posedge, check #1 later.
  task automatic step(input string tag, input bit ev, input logic [WIDTH-1:0] ed,
                      input bit rv, input logic [WIDTH-1:0] rd, input bit clr,
                      output bit acc);
    logic [WIDTH-1:0] e;
    bit rdy;
    @(negedge clk);
    exp_valid = ev; exp_data = ed; res_valid = rv; res_data = rd; clear = clr;
    @(posedge clk);
    acc = 0; m_match = 0; m_mism = 0;
    if (clr) begin
      model_reset();
    end else begin
      rdy = (mq.size() < DEPTH);
      if (rv) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          if (e == rd) begin
            m_match = 1;
            if (m_pass < SAT) m_pass++;
          end else begin
            m_mism = 1;
            if (m_err < SAT) m_err++;
            if (!m_fe_v) begin
              m_fe_v = 1; m_fe_idx = m_cidx; m_fe_exp = e; m_fe_got = rd;
            end
          end
          if (m_cidx < SAT) m_cidx++;
        end else begin
          m_unexp = 1;
        end
      end
      if (ev && rdy) begin
        mq.push_back(ed);
        acc = 1;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    bit a;
    step(tag, 0, '0, 0, '0, 0, a);
  endtask

  task automatic do_clear();
    bit a;
    step("clr", 0, '0, 0, '0, 1, a);
  endtask

  task automatic seq1(input string tag);
    bit a;
    step(tag, 1, 32'h00000000, 0, '0, 0, a);
    step(tag, 1, 32'hFFFFFFFF, 0, '0, 0, a);
    step(tag, 1, 32'h55555555, 0, '0, 0, a);
    step(tag, 0, '0, 1, 32'h00000000, 0, a);
    step(tag, 0, '0, 1, 32'hFFFFFFFF, 0, a);
    step(tag, 0, '0, 1, 32'h55555555, 0, a);
    chk({tag, "_pass3"}, 32'(pass_count), 32'd3);
    chk({tag, "_err0"},  32'(err_count),  32'd0);
    chk({tag, "_lvl0"},  32'(fifo_level), 32'd0);
    idle(tag);
  endtask

  initial begin
    bit a;
    logic [WIDTH-1:0] hold_d;
    bit hold_v;
    int nmatch;

    rst_n = 0; clear = 0; exp_valid = 0; exp_data = '0; res_valid = 0; res_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;

    // 1: three matching words
    seq1("t1");

    // 2: single mismatch on a fresh scoreboard
    do_clear();
    step("t2", 1, 32'h55555555, 0, '0, 0, a);
    step("t2", 0, '0, 1, 32'haaaaaaaa, 0, a);
    chk("t2_mism", 32'(mismatch), 32'd1);
    chk("t2_err1", 32'(err_count), 32'd1);
`ifdef CHK_ERR_LOG_EN
    chk("t2_fe_idx", 32'(first_err_idx), 32'd0);
    chk("t2_fe_exp", first_err_exp, 32'h55555555);
    chk("t2_fe_got", first_err_got, 32'haaaaaaaa);
`endif
    idle("t2");

    // 3: five back-to-back pushes into a depth-4 FIFO
    do_clear();
    for (int i = 0; i < 4; i++) step("t3", 1, 32'(100 + i), 0, '0, 0, a);
    chk("t3_full_ready", 32'(exp_ready), 32'd0);
    step("t3", 1, 32'd104, 1, 32'd100, 0, a);
    chk("t3_held", 32'(a), 32'd0);
    step("t3", 1, 32'd104, 0, '0, 0, a);
    chk("t3_accept", 32'(a), 32'd1);
    for (int i = 1; i < 5; i++) step("t3", 0, '0, 1, 32'(100 + i), 0, a);
    idle("t3");

    // 4: result against empty FIFO with a same-cycle push
    do_clear();
    step("t4", 1, 32'h12345678, 1, 32'h12345678, 0, a);
    chk("t4_unexp", 32'(unexpected), 32'd1);
    chk("t4_lvl1",  32'(fifo_level), 32'd1);
    idle("t4");
    chk("t4_nopulse", 32'(match | mismatch), 32'd0);

    // 5: clear together with res_valid
    do_clear();
    for (int i = 0; i < 3; i++) step("t5", 1, 32'(7 + i), 0, '0, 0, a);
    step("t5", 0, '0, 1, 32'd7, 1, a);
    idle("t5");
    chk("t5_nopulse", 32'(match | mismatch), 32'd0);
    chk("t5_lvl0", 32'(fifo_level), 32'd0);

    // 6: asynchronous reset with two words queued
    step("t6", 1, 32'hdead0001, 0, '0, 0, a);
    step("t6", 1, 32'hdead0002, 1, 32'hdead0001, 0, a);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("t6_async_ready", 32'(exp_ready), 32'd1);
    chk("t6_async_lvl",   32'(fifo_level), 32'd0);
    chk("t6_async_pulse", 32'(match | mismatch), 32'd0);
    chk("t6_async_pass",  32'(pass_count), 32'd0);
    @(negedge clk);
    exp_valid = 0; res_valid = 0;
    @(negedge clk);
    rst_n = 1;
    seq1("t6b");

    // Counter saturation
    do_clear();
    for (int i = 0; i < SAT + 3; i++) begin
      step("satp", 1, 32'(i), 0, '0, 0, a);
      step("satp", 0, '0, 1, 32'(i), 0, a);
    end
    chk("sat_pass", 32'(pass_count), 32'(SAT));
    for (int i = 0; i < SAT + 3; i++) begin
      step("sate", 1, 32'(i), 0, '0, 0, a);
      step("sate", 0, '0, 1, ~32'(i), 0, a);
    end
    chk("sat_err", 32'(err_count), 32'(SAT));

    // Randomized traffic; the source holds an unaccepted word until taken.
    do_clear();
    hold_v = 0; hold_d = '0;
    for (int c = 0; c < 400; c++) begin
      logic [WIDTH-1:0] rd;
      bit rv, clr;
      if (!hold_v && ($urandom_range(0, 2) != 0)) begin
        hold_v = 1;
        hold_d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      end
      rv = ($urandom_range(0, 2) == 0);
      nmatch = $urandom_range(0, 3);
      rd = (mq.size() > 0 && nmatch != 0) ? mq[0] : $urandom;
      clr = ($urandom_range(0, 79) == 0);
      step("rnd", hold_v, hold_d, rv, rd, clr, a);
      if (a) hold_v = 0;
    end
    idle("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
